demultiplexor_tdm: RTL and testbench

DEMULTIPLEXOR_TDM -- requirements
Module: demultiplexor_tdm

---
 rtl/demux_pkg.sv | 16 +
 rtl/demultiplexor_tdm_contador_ranura.sv | 37 +++
 rtl/demultiplexor_tdm.sv | 147 ++++++++++++++
 tb/tb_demultiplexor_tdm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types for the TDM demultiplexor: FSM states and slot count.
// No logic; imported by demultiplexor_tdm and contador_ranura.
package demux_pkg;

    localparam int NUM_RANURAS = 4;

    typedef logic [1:0] ranura_t;

    localparam ranura_t ULTIMA_RANURA = ranura_t'(NUM_RANURAS - 1);

    typedef enum logic {
        ESPERA = 1'b0,
        RECIBE = 1'b1
    } estado_t;

endpackage

// File: rtl/demultiplexor_tdm_contador_ranura.sv
// Slot counter: 2-bit register with clear, load-1 and increment (priority in that order).
// Latency: 1 cycle; no backpressure, controls are single-cycle strobes.
module contador_ranura
    import demux_pkg::*;
(
    input  logic    i_Clk,
    input  logic    i_Rst_n,
    input  logic    i_Clr,
    input  logic    i_Carga1,
    input  logic    i_Inc,
    output ranura_t o_Cuenta
);

    ranura_t cuenta_q, cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (i_Clr) begin
            cuenta_d = '0;
        end else if (i_Carga1) begin
            cuenta_d = ranura_t'(1);
        end else if (i_Inc) begin
            cuenta_d = cuenta_q + ranura_t'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign o_Cuenta = cuenta_q;

endmodule

// File: rtl/demultiplexor_tdm.sv
// TDM demux: collects 4 serial slots into shadow regs, publishes all four together.
// Latency: 1 cycle from slot-3 beat to outputs; no backpressure, i_Valido=0 just stalls.
// Optional per-beat even parity check enabled by DEMUX_PARIDAD_EN.
module demultiplexor_tdm
    import demux_pkg::*;
#(
    parameter int ANCHO = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic [ANCHO-1:0] i_Dato,
    input  logic             i_Valido,
    input  logic             i_Inicio,
`ifdef DEMUX_PARIDAD_EN
    input  logic             i_Paridad,
`endif
    output logic [ANCHO-1:0] o_Salida_0,
    output logic [ANCHO-1:0] o_Salida_1,
    output logic [ANCHO-1:0] o_Salida_2,
    output logic [ANCHO-1:0] o_Salida_3,
    output logic             o_Listo,
    output logic             o_Error,
    output logic             o_Ocupado
);

    estado_t estado_q, estado_d;
    // Slot 3 is never shadowed: it goes straight to the output register.
    logic [NUM_RANURAS-2:0][ANCHO-1:0] sombra_q, sombra_d;
    logic [NUM_RANURAS-1:0][ANCHO-1:0] salida_q, salida_d;
    logic    listo_q, listo_d;
    logic    error_q, error_d;
    logic    clr, carga1, inc;
    ranura_t cuenta;
    logic    par_err;
    logic    malo;

    contador_ranura u_contador (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Clr    (clr),
        .i_Carga1 (carga1),
        .i_Inc    (inc),
        .o_Cuenta (cuenta)
    );

`ifdef DEMUX_PARIDAD_EN
    logic malo_q, malo_d;

    assign par_err = ((^i_Dato) != i_Paridad);
    assign malo    = malo_q;

    always_comb begin
        malo_d = malo_q;
        if (i_Valido) begin
            if (i_Inicio) begin
                malo_d = par_err;
            end else if (estado_q == RECIBE) begin
                malo_d = malo_q | par_err;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            malo_q <= 1'b0;
        end else begin
            malo_q <= malo_d;
        end
    end
`else
    assign par_err = 1'b0;
    assign malo    = 1'b0;
`endif

    always_comb begin
        estado_d = estado_q;
        sombra_d = sombra_q;
        salida_d = salida_q;
        listo_d  = 1'b0;
        error_d  = 1'b0;
        clr      = 1'b0;
        carga1   = 1'b0;
        inc      = 1'b0;
        if (i_Valido) begin
            case (estado_q)
                ESPERA: begin
                    if (i_Inicio) begin
                        sombra_d[0] = i_Dato;
                        carga1      = 1'b1;
                        estado_d    = RECIBE;
                    end
                end
                RECIBE: begin
                    if (i_Inicio) begin
                        // Restart: abandon the partial frame, this beat becomes slot 0.
                        error_d     = 1'b1;
                        sombra_d[0] = i_Dato;
                        carga1      = 1'b1;
                    end else if (cuenta == ULTIMA_RANURA) begin
                        clr      = 1'b1;
                        estado_d = ESPERA;
                        if (malo || par_err) begin
                            error_d = 1'b1;
                        end else begin
                            salida_d[NUM_RANURAS-1]   = i_Dato;
                            salida_d[NUM_RANURAS-2:0] = sombra_q;
                            listo_d                   = 1'b1;
                        end
                    end else begin
                        for (int k = 0; k < NUM_RANURAS - 1; k++) begin
                            if (cuenta == ranura_t'(k)) begin
                                sombra_d[k] = i_Dato;
                            end
                        end
                        inc = 1'b1;
                    end
                end
                default: estado_d = ESPERA;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            estado_q <= ESPERA;
            sombra_q <= '0;
            salida_q <= '0;
            listo_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            sombra_q <= sombra_d;
            salida_q <= salida_d;
            listo_q  <= listo_d;
            error_q  <= error_d;
        end
    end

    assign o_Salida_0 = salida_q[0];
    assign o_Salida_1 = salida_q[1];
    assign o_Salida_2 = salida_q[2];
    assign o_Salida_3 = salida_q[3];
    assign o_Listo    = listo_q;
    assign o_Error    = error_q;
    assign o_Ocupado  = (estado_q == RECIBE);

endmodule

// File: tb/tb_demultiplexor_tdm.sv
// Scoreboard bench for demultiplexor_tdm: stimulus pushes expected publish/abort events,
// a negedge monitor pops and compares them whenever o_Listo or o_Error is seen.
module tb_demultiplexor_tdm;

    logic       clk;
    logic       rst_n;
    logic [3:0] dato;
    logic       valido;
    logic       inicio;
    logic       paridad;
    logic [3:0] s0, s1, s2, s3;
    logic       listo, error, ocupado;

    int tests;
    int fails;

    // {err, s3, s2, s1, s0}
    logic [16:0] esperado_q[$];

    demultiplexor_tdm #(.ANCHO(4)) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_Dato     (dato),
        .i_Valido   (valido),
        .i_Inicio   (inicio),
`ifdef DEMUX_PARIDAD_EN
        .i_Paridad  (paridad),
`endif
        .o_Salida_0 (s0),
        .o_Salida_1 (s1),
        .o_Salida_2 (s2),
        .o_Salida_3 (s3),
        .o_Listo    (listo),
        .o_Error    (error),
        .o_Ocupado  (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] ev(input logic err, input logic [3:0] a, b, c, d);
        return {err, d, c, b, a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_salidas(input string nm, input logic [3:0] a, b, c, d);
        chk(nm, {16'h0, s3, s2, s1, s0}, {16'h0, d, c, b, a});
    endtask

    // One valid beat, consumed on the next rising edge; returns #1 after that edge.
    task automatic beat(input logic ini, input logic [3:0] d, input logic mala_par);
        valido  = 1'b1;
        inicio  = ini;
        dato    = d;
        paridad = (^d) ^ mala_par;
        @(posedge clk);
        #1;
        valido  = 1'b0;
        inicio  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (listo && error) begin
            tests++;
            fails++;
            $display("FAIL listo_y_error: got both high, required exclusive");
        end
        if (listo || error) begin
            tests++;
            if (esperado_q.size() == 0) begin
                fails++;
                $display("FAIL evento_inesperado: got listo=%0b error=%0b salidas=%h%h%h%h, required no event",
                         listo, error, s3, s2, s1, s0);
            end else begin
                logic [16:0] e;
                logic [16:0] a;
                e = esperado_q.pop_front();
                a = {error, s3, s2, s1, s0};
                if (a !== e) begin
                    fails++;
                    $display("FAIL evento: got err=%0b salidas=%h required err=%0b salidas=%h",
                             a[16], a[15:0], e[16], e[15:0]);
                end
            end
        end
    end

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        valido  = 1'b0;
        inicio  = 1'b0;
        dato    = 4'h0;
        paridad = 1'b0;

        idle(3);
        chk_salidas("reset_salidas", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("reset_listo", {31'h0, listo}, 0);
        chk("reset_error", {31'h0, error}, 0);
        chk("reset_ocupado", {31'h0, ocupado}, 0);
        rst_n = 1'b1;
        idle(1);

        // Back-to-back frame A,B,C,D
        beat(1'b1, 4'hA, 1'b0);
        chk("bb_ocupado", {31'h0, ocupado}, 1);
        beat(1'b0, 4'hB, 1'b0);
        beat(1'b0, 4'hC, 1'b0);
        esperado_q.push_back(ev(1'b0, 4'hA, 4'hB, 4'hC, 4'hD));
        beat(1'b0, 4'hD, 1'b0);
        chk("bb_listo_lat", {31'h0, listo}, 1);
        chk("bb_ocupado_fin", {31'h0, ocupado}, 0);
        chk_salidas("bb_salidas", 4'hA, 4'hB, 4'hC, 4'hD);
        idle(1);
        chk("bb_listo_pulso", {31'h0, listo}, 0);

        // Same frame with 3-cycle gaps between beats
        beat(1'b1, 4'hA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("gap_ocupado_0", {31'h0, ocupado}, 1);
        end
        beat(1'b0, 4'hB, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("gap_ocupado_1", {31'h0, ocupado}, 1);
        end
        beat(1'b0, 4'hC, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("gap_ocupado_2", {31'h0, ocupado}, 1);
            chk("gap_sin_listo", {31'h0, listo}, 0);
        end
        esperado_q.push_back(ev(1'b0, 4'hA, 4'hB, 4'hC, 4'hD));
        beat(1'b0, 4'hD, 1'b0);
        chk("gap_listo_lat", {31'h0, listo}, 1);
        chk("gap_ocupado_fin", {31'h0, ocupado}, 0);
        idle(1);

        // Stray non-start beat while idle is dropped
        beat(1'b0, 4'h3, 1'b0);
        chk("espera_ocupado", {31'h0, ocupado}, 0);
        chk_salidas("espera_salidas", 4'hA, 4'hB, 4'hC, 4'hD);
        idle(2);

        // Restart mid-frame: error on third beat, then 5,6,7,8
        beat(1'b1, 4'h1, 1'b0);
        beat(1'b0, 4'h2, 1'b0);
        esperado_q.push_back(ev(1'b1, 4'hA, 4'hB, 4'hC, 4'hD));
        beat(1'b1, 4'h5, 1'b0);
        chk("reinicio_error_lat", {31'h0, error}, 1);
        chk("reinicio_ocupado", {31'h0, ocupado}, 1);
        beat(1'b0, 4'h6, 1'b0);
        chk("reinicio_error_pulso", {31'h0, error}, 0);
        beat(1'b0, 4'h7, 1'b0);
        esperado_q.push_back(ev(1'b0, 4'h5, 4'h6, 4'h7, 4'h8));
        beat(1'b0, 4'h8, 1'b0);
        chk("reinicio_listo", {31'h0, listo}, 1);
        chk_salidas("reinicio_salidas", 4'h5, 4'h6, 4'h7, 4'h8);
        idle(1);

        // Reset mid-frame, then a full frame 9,8,7,6
        beat(1'b1, 4'h1, 1'b0);
        beat(1'b0, 4'h2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_salidas("rst_medio_salidas", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("rst_medio_ocupado", {31'h0, ocupado}, 0);
        chk("rst_medio_error", {31'h0, error}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_error", {31'h0, error}, 0);
        beat(1'b1, 4'h9, 1'b0);
        beat(1'b0, 4'h8, 1'b0);
        beat(1'b0, 4'h7, 1'b0);
        esperado_q.push_back(ev(1'b0, 4'h9, 4'h8, 4'h7, 4'h6));
        beat(1'b0, 4'h6, 1'b0);
        chk_salidas("post_rst_salidas", 4'h9, 4'h8, 4'h7, 4'h6);
        idle(1);

`ifdef DEMUX_PARIDAD_EN
        // Bad parity on slot 2: abort at completion, outputs keep 9,8,7,6
        beat(1'b1, 4'h1, 1'b0);
        beat(1'b0, 4'h2, 1'b0);
        beat(1'b0, 4'h3, 1'b1);
        esperado_q.push_back(ev(1'b1, 4'h9, 4'h8, 4'h7, 4'h6));
        beat(1'b0, 4'h4, 1'b0);
        chk("par_error", {31'h0, error}, 1);
        chk("par_sin_listo", {31'h0, listo}, 0);
        chk("par_ocupado", {31'h0, ocupado}, 0);
        chk_salidas("par_salidas", 4'h9, 4'h8, 4'h7, 4'h6);
        idle(1);
`endif

        idle(3);
        chk("eventos_pendientes", esperado_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
